// File: rtl/moore_seq_detector_pkg.sv
// Shared types and constants for the serial pattern detector.
// Optional match counter is enabled with the SEQ_DET_COUNT_EN macro.
package seq_det_pkg;

    localparam logic [3:0] PAT_DEF   = 4'b1011;
    localparam int         CNT_W_DEF = 8;
    localparam int         CNT_SAT   = (1 << CNT_W_DEF) - 1;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_SHIFT = 2'd2
    } op_e;

    // Width needed to hold a matched-prefix length of 0..pat_w
    function automatic int st_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Stream, configuration and status signals of the serial pattern detector.
// master drives the bit stream and controls; slave is the detector.
interface moore_seq_detector_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int ST_W = st_w(PAT_W);

    logic              din_valid;
    logic              din;
    logic              overlap;
    logic              pat_load;
    logic [PAT_W-1:0]  pat_in;
    logic              cnt_clr;
    logic [ST_W-1:0]   state_o;
    logic              match;
    logic [CNT_W-1:0]  match_count;

    modport master (
        output din_valid, din, overlap, pat_load, pat_in, cnt_clr,
        input  state_o, match, match_count
    );

    modport slave (
        input  din_valid, din, overlap, pat_load, pat_in, cnt_clr,
        output state_o, match, match_count
    );
endinterface

// File: rtl/moore_seq_detector_prefix_match.sv
// Longest pattern prefix that ends at the newest history bit.
// Purely combinational; no backpressure.
module seq_prefix_match
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    localparam int ST_W = st_w(PAT_W)
) (
    input  logic [PAT_W-1:0] hist,
    input  logic [PAT_W-1:0] pat,
    output logic [ST_W-1:0]  len
);
    logic [PAT_W:0] hit;

    assign hit[0] = 1'b1;

    for (genvar k = 1; k <= PAT_W; k++) begin : g_cmp
        assign hit[k] = (hist[k-1:0] == pat[PAT_W-1 -: k]);
    end

    always_comb begin
        len = '0;
        for (int k = PAT_W; k >= 1; k--) begin
            if (hit[k] && (len == '0)) begin
                len = ST_W'(k);
            end
        end
    end
endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with loadable pattern, overlap mode and
// optional saturating match counter (SEQ_DET_COUNT_EN); outputs follow a consumed bit by one cycle.
module moore_seq_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEF),
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    moore_seq_detector_if.slave  bus
);
    localparam int ST_W = st_w(PAT_W);

    logic [ST_W-1:0]  state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] eff_hist;
    logic [ST_W-1:0]  pm_len;
    logic             at_match;
    logic             hit;
    op_e              op;

    assign at_match = (state_q == ST_W'(PAT_W));

    // Non-overlap restart: after a full match only the new bit survives
    always_comb begin
        eff_hist = {hist_q[PAT_W-2:0], bus.din};
        if (!bus.overlap && at_match) begin
            eff_hist = {{(PAT_W-1){1'b0}}, bus.din};
        end
    end

    seq_prefix_match #(.PAT_W(PAT_W)) u_prefix (
        .hist (eff_hist),
        .pat  (pat_q),
        .len  (pm_len)
    );

    always_comb begin
        op      = OP_HOLD;
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        if (bus.pat_load) begin
            op = OP_LOAD;
        end else if (bus.din_valid) begin
            op = OP_SHIFT;
        end
        case (op)
            OP_LOAD: begin
                pat_d   = bus.pat_in;
                state_d = '0;
                hist_d  = '0;
            end
            OP_SHIFT: begin
                hist_d  = eff_hist;
                state_d = pm_len;
            end
            default: ;
        endcase
        hit = (op == OP_SHIFT) && (pm_len == ST_W'(PAT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            hist_q  <= '0;
            pat_q   <= PAT_RST;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
        end
    end

    assign bus.state_o = state_q;
    assign bus.match   = at_match;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.match_count = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt      = bus.cnt_clr ^ hit;
    assign bus.match_count = '0;
`endif
endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench for moore_seq_detector (PAT_W=4, CNT_W=2 to reach saturation quickly).
module tb_moore_seq_detector;
    import seq_det_pkg::*;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        int    st;
        int    mt;
        int    cnt;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   obs_st, obs_mt, obs_cnt;

    // reference model state
    int               m_state;
    logic [PAT_W-1:0] m_hist;
    logic [PAT_W-1:0] m_pat;
    int               m_cnt;

    always #5 clk = ~clk;

    moore_seq_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    moore_seq_detector #(.PAT_W(PAT_W), .PAT_RST(4'b1011), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int longest(input logic [PAT_W-1:0] h, input logic [PAT_W-1:0] p);
        for (int k = PAT_W; k >= 1; k--) begin
            int mask;
            mask = (1 << k) - 1;
            if ((int'(h) & mask) == (int'(p) >> (PAT_W - k))) return k;
        end
        return 0;
    endfunction

    task automatic step(input bit r, input bit v, input bit d, input bit o, input bit l,
                        input logic [PAT_W-1:0] pin, input bit clr, input string tag);
        exp_t e, g;
        logic [PAT_W-1:0] h;
        @(negedge clk);
        rst           = r;
        bus.din_valid = v;
        bus.din       = d;
        bus.overlap   = o;
        bus.pat_load  = l;
        bus.pat_in    = pin;
        bus.cnt_clr   = clr;
        if (r) begin
            m_state = 0; m_hist = '0; m_pat = 4'b1011; m_cnt = 0;
        end else begin
            if (l) begin
                m_pat = pin; m_state = 0; m_hist = '0;
            end else if (v) begin
                if (!o && m_state == PAT_W) h = {{(PAT_W-1){1'b0}}, d};
                else                        h = {m_hist[PAT_W-2:0], d};
                m_hist  = h;
                m_state = longest(h, m_pat);
                if (m_state == PAT_W && m_cnt < CNT_MAX) m_cnt++;
            end
            if (clr) m_cnt = 0;
        end
        e.st  = m_state;
        e.mt  = (m_state == PAT_W) ? 1 : 0;
        e.cnt = CNT_ON ? m_cnt : 0;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        obs_st  = int'(bus.state_o);
        obs_mt  = int'(bus.match);
        obs_cnt = int'(bus.match_count);
        check({g.tag, "_state"}, obs_st, g.st);
        check({g.tag, "_match"}, obs_mt, g.mt);
        check({g.tag, "_count"}, obs_cnt, g.cnt);
    endtask

    task automatic send(input bit d, input bit o, input string tag);
        step(1'b0, 1'b1, d, o, 1'b0, '0, 1'b0, tag);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, "rst");
    endtask

    initial begin
        logic [6:0] stream;
        stream = 7'b1011011;
        rst = 1'b1;
        bus.din_valid = 0; bus.din = 0; bus.overlap = 1; bus.pat_load = 0;
        bus.pat_in = '0; bus.cnt_clr = 0;

        do_reset();
        check("rst_state", obs_st, 0);
        check("rst_match", obs_mt, 0);

        // reset in the middle of a partial match, with a valid bit pending
        send(1, 1, "mid_b1"); send(0, 1, "mid_b2"); send(1, 1, "mid_b3");
        check("mid_state3", obs_st, 3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, "mid_rst");
        check("mid_rst_state", obs_st, 0);
        check("mid_rst_count", obs_cnt, 0);

        // overlapping detection of 1011
        for (int i = 6; i >= 0; i--) begin
            send(stream[i], 1, $sformatf("ov_b%0d", 7 - i));
            if (i == 3) check("ov_b4_match", obs_mt, 1);
            if (i == 2) check("ov_b5_state", obs_st, 2);
        end
        check("ov_b7_match", obs_mt, 1);
        check("ov_count", obs_cnt, CNT_ON ? 2 : 0);

        // non-overlapping detection
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            send(stream[i], 0, $sformatf("no_b%0d", 7 - i));
            if (i == 3) check("no_b4_match", obs_mt, 1);
            if (i == 2) check("no_b5_state", obs_st, 0);
            if (i == 1) check("no_b6_state", obs_st, 1);
        end
        check("no_b7_state", obs_st, 1);
        check("no_b7_match", obs_mt, 0);
        check("no_count", obs_cnt, CNT_ON ? 1 : 0);

        // idle while matched
        do_reset();
        send(1, 1, "id_b1"); send(0, 1, "id_b2"); send(1, 1, "id_b3"); send(1, 1, "id_b4");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, $sformatf("idle%0d", i));
            check("idle_match", obs_mt, 1);
            check("idle_count", obs_cnt, CNT_ON ? 1 : 0);
        end
        send(0, 1, "id_after");
        check("id_after_state", obs_st, 2);

        // pattern load wins over a simultaneous valid bit
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, "load");
        check("load_state", obs_st, 0);
        send(0, 1, "p6_b1"); send(1, 1, "p6_b2"); send(1, 1, "p6_b3");
        check("p6_b3_match", obs_mt, 0);
        send(0, 1, "p6_b4");
        check("p6_b4_match", obs_mt, 1);

        // all-ones pattern: counter saturation, then clear beats increment
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, "load1111");
        check("load1111_count", obs_cnt, 0);
        for (int i = 0; i < 7; i++) send(1, 1, $sformatf("ones%0d", i));
        check("sat_count", obs_cnt, CNT_ON ? CNT_MAX : 0);
        check("sat_state", obs_st, PAT_W);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, "clr_hit");
        check("clr_hit_count", obs_cnt, 0);
        check("clr_hit_match", obs_mt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised Moore-style serial pattern detector: the successor to the fixed-pattern TinyTapeout Moore machine.
- Generalised in pattern width. The pattern is runtime-loadable. Adds overlap/non-overlap mode, an input-valid qualifier, and an optional saturating match counter.
- Sits between the pin-level input synchroniser and the `uo_out` mapping inside a `tt_um_*` top.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..8.
- PAT_RST, 4'b1011 (sized PAT_W), pattern register value after reset.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- din_valid  in  1  qualifies `din`; the bit is consumed only when high.
- din  in  1  serial data bit.
- overlap  in  1  1 = overlapping matches allowed; 0 = restart after a match. Sampled with each consumed bit.
- pat_load  in  1  load `pat_in` into the pattern register.
- pat_in  in  PAT_W  new pattern; MSB is compared first.
- cnt_clr  in  1  clear the match counter.
- state_o  out  $clog2(PAT_W+1)  current state (matched-prefix length).
- match  out  1  Moore output; high iff state == PAT_W.
- match_count  out  CNT_W  saturating count of matches.

Behaviour:
- States 0..PAT_W. State k means the last k consumed bits equal `pattern[PAT_W-1 -: k]`.
- All outputs are registered or decoded only from registered state; there are no combinational paths from inputs.
- Reset (rst=1 at an edge): state=0, history=0, pattern=PAT_RST, match_count=0, match=0. Reset has priority over all other inputs, including mid-sequence.
- Priority order after rst: pat_load, then din_valid.
  - pat_load=1: pattern←pat_in, state←0, history←0. Any simultaneous `din` is discarded.
- din_valid=1 and pat_load=0:
  - Shift `din` into a PAT_W-bit history register, LSB = newest bit.
  - Next state = the largest k in 0..PAT_W such that the newest k bits of the effective history equal the top k pattern bits.
  - Effective history: if overlap=0 and current state == PAT_W, use only the new bit (older history treated as empty). Otherwise use the full updated history. The non-overlap case also clears the stored history to just the new bit.
- din_valid=0: state, history and match hold. `match` stays high while idle in state PAT_W.
- Latency: a bit consumed at edge N affects state_o/match from edge N onward, i.e. visible in the following cycle.
- match_count:
  - Increments by 1 on each consumed bit whose next state is PAT_W. This includes PAT_W→PAT_W transitions in overlap mode, e.g. an all-ones pattern.
  - Saturates at 2^CNT_W−1.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- Only the lower PAT_W bits of pat_in are used. pattern is not exported.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined: match_count, the saturating logic and cnt_clr are active as described above.
- Undefined: the counter register is not built, match_count is tied to 0, and cnt_clr is ignored. Port list is unchanged.

Decomposition:
- Package `seq_det_pkg`:
  - state-width function `st_w(PAT_W)`;
  - default pattern constant;
  - CNT_W default;
  - localparam for counter saturation value.
- One sub-module, `seq_prefix_match`: purely combinational. Takes the effective history and the pattern; returns the longest matching prefix length via a per-k compare plus a priority encode from k=PAT_W down to 0.
- The FSM, history and counter registers live in `moore_seq_detector`.

Test Plan:
- Reset with rst=1 mid-stream (state 3) → next cycle state_o=0, match=0, match_count=0, pattern=1011.
- PAT_W=4, pattern 1011, overlap=1, stream 1,0,1,1,0,1,1 all valid → match high after bits 4 and 7; state_o after bit 5 = 2; match_count=2.
- Same stream with overlap=0 → match only after bit 4; state_o after bits 5..7 = 0,1,1; match_count=1.
- din_valid low for 5 cycles while in state 4 → match held high, count unchanged. Then valid 0 → state 2 (overlap=1).
- pat_load with pat_in=0110 and din_valid=1 in the same cycle → din ignored, state 0. Stream 0,1,1,0 → match after bit 4.
- CNT_W=2, pattern 1111, overlap=1, seven consecutive 1s → count saturates at 3. cnt_clr asserted together with a match-causing bit → count 0.
